// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 target modelling a 23LC512-style serial SRAM.
// SCK/MOSI/CE are oversampled on clk through 2-flop synchronizers; a local
// byte array backs the SPI READ/WRITE commands and a backdoor port allows
// preload and inspection from the system side.
// SPI handshake: a byte is complete on the SCK rise with bit_cnt==7; the
// backdoor has no handshake (bk_write is a single-cycle write strobe).
module spi_sram_target #(
  parameter int         MEM_DEPTH  = 256,
  parameter int         MEM_AW     = 8,
  parameter logic [7:0] STATUS_VAL = 8'h40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_ce_n,
  output logic              spi_miso,
  output logic              active,
  input  logic              bk_write,
  input  logic [MEM_AW-1:0] bk_addr,
  input  logic [7:0]        bk_wdata,
  output logic [7:0]        bk_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_READ, S_WRITE, S_RDSR, S_IGNORE
  } state_t;

  logic [7:0] mem [MEM_DEPTH];

  // Synchronizer stages; CE idles high so its stages reset to 1.
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic ce_meta_q, ce_sync_q;

  state_t      state_q, state_d, cur_st;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  rx_q, rx_d, rx_byte;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_mode_q, rd_mode_d;
  logic        miso_q, miso_d;
  logic        active_q, active_d;
  logic [7:0]  bk_rdata_q;

  logic              sck_rise, sck_fall;
  logic [15:0]       lo_addr, addr_inc;
  logic [MEM_AW-1:0] lo_idx, inc_idx;
  logic              spi_we;
  logic [MEM_AW-1:0] spi_widx;
  logic [7:0]        spi_wbyte;

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign rx_byte  = {rx_q[6:0], mosi_sync_q};
  assign lo_addr  = {addr_q[15:8], rx_byte};
  assign addr_inc = addr_q + 16'd1;
  assign lo_idx   = MEM_AW'(lo_addr);
  assign inc_idx  = MEM_AW'(addr_inc);

  assign spi_miso = miso_q;
  assign active   = active_q;
  assign bk_rdata = bk_rdata_q;

  // Next-state decode: CE high aborts everything, otherwise act on SCK edges.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    rd_mode_d = rd_mode_q;
    miso_d    = miso_q;
    active_d  = active_q;
    cur_st    = state_q;
    spi_we    = 1'b0;
    spi_widx  = '0;
    spi_wbyte = 8'h00;
    if (ce_sync_q) begin
      state_d  = S_IDLE;
      cnt_d    = 3'd0;
      miso_d   = 1'b0;
      active_d = 1'b0;
    end else begin
      active_d = 1'b1;
      // A rise coinciding with CE fall is taken as the first command bit.
      cur_st  = (state_q == S_IDLE) ? S_CMD : state_q;
      state_d = cur_st;
      if (sck_rise) begin
        rx_d  = rx_byte;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          case (cur_st)
            S_CMD: begin
              case (rx_byte)
                8'h03: begin state_d = S_ADDR_HI; rd_mode_d = 1'b1; end
                8'h02: begin state_d = S_ADDR_HI; rd_mode_d = 1'b0; end
                8'h05: begin state_d = S_RDSR; tx_d = STATUS_VAL; end
                default: state_d = S_IGNORE;
              endcase
            end
            S_ADDR_HI: begin
              addr_d[15:8] = rx_byte;
              state_d      = S_ADDR_LO;
            end
            S_ADDR_LO: begin
              addr_d[7:0] = rx_byte;
              if (rd_mode_q) begin
                tx_d    = mem[lo_idx];
                state_d = S_READ;
              end else begin
                state_d = S_WRITE;
              end
            end
            S_READ: begin
              addr_d = addr_inc;
              tx_d   = mem[inc_idx];
            end
            S_WRITE: begin
              spi_we    = 1'b1;
              spi_widx  = MEM_AW'(addr_q);
              spi_wbyte = rx_byte;
              addr_d    = addr_inc;
            end
            S_RDSR:  tx_d = STATUS_VAL;
            default: ;
          endcase
        end
      end
      if (sck_fall && (cur_st == S_READ || cur_st == S_RDSR)) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (cur_st != S_READ && cur_st != S_RDSR) miso_d = 1'b0;
    end
  end

  // Synchronizers, FSM and registered SPI outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      ce_meta_q   <= 1'b1;
      ce_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 16'h0000;
      rd_mode_q   <= 1'b0;
      miso_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      sck_meta_q  <= spi_clk;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      ce_meta_q   <= spi_ce_n;
      ce_sync_q   <= ce_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rd_mode_q   <= rd_mode_d;
      miso_q      <= miso_d;
      active_q    <= active_d;
    end
  end

  // Backing array; the SPI write is issued last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (bk_write) mem[bk_addr] <= bk_wdata;
    if (spi_we)   mem[spi_widx] <= spi_wbyte;
  end

  // Backdoor read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) bk_rdata_q <= 8'h00;
    else        bk_rdata_q <= mem[bk_addr];
  end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: directed SPI transactions against spi_sram_target.
// Every transferred byte pushes its expected MISO byte; a monitor rebuilds
// MISO bytes on SCK rises and pops/compares them. Backdoor reads are checked
// directly against hand-computed values.
`timescale 1ns/1ps
module tb_spi_sram_target;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_ce_n = 1'b1;
  logic          spi_miso;
  logic          active;
  logic          bk_write = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [7:0]    bk_wdata = 8'h00;
  logic [7:0]    bk_rdata;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  spi_sram_target #(.MEM_DEPTH(256), .MEM_AW(AW), .STATUS_VAL(8'h40)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_ce_n (spi_ce_n),
    .spi_miso (spi_miso),
    .active   (active),
    .bk_write (bk_write),
    .bk_addr  (bk_addr),
    .bk_wdata (bk_wdata),
    .bk_rdata (bk_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver tasks
  task automatic bk_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bk_write = 1'b1; bk_addr = a; bk_wdata = d;
    @(negedge clk);
    bk_write = 1'b0;
  endtask

  task automatic bk_chk(input string name, input logic [AW-1:0] a, input logic [7:0] e);
    @(negedge clk);
    bk_addr = a;
    @(negedge clk);
    check8(name, bk_rdata, e);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      wclk(8);
      spi_clk = 1'b1;
      wclk(8);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    spi_bits(b, 8);
  endtask

  task automatic ce_lo();
    @(negedge clk);
    spi_ce_n = 1'b0;
    wclk(8);
    check8("active_high", {7'd0, active}, 8'h01);
  endtask

  task automatic ce_hi();
    wclk(8);
    spi_ce_n = 1'b1;
    wclk(8);
  endtask

  // Monitor: assemble MISO bytes as the initiator would, compare against queue
  initial begin
    logic [7:0] mbyte;
    int mcnt;
    mbyte = 8'h00;
    mcnt = 0;
    forever begin
      @(posedge spi_clk or posedge spi_ce_n);
      if (spi_ce_n) begin
        mcnt = 0;
      end else begin
        mbyte = {mbyte[6:0], spi_miso};
        mcnt++;
        if (mcnt == 8) begin
          mcnt = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL miso_unexpected: got %02h expected none", mbyte);
          end else begin
            check8("miso_byte", mbyte, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    // Reset state
    wclk(4);
    check8("rst_miso", {7'd0, spi_miso}, 8'h00);
    check8("rst_active", {7'd0, active}, 8'h00);
    check8("rst_bk_rdata", bk_rdata, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    wclk(4);

    // Preloads
    bk_wr(8'h10, 8'hDE); bk_wr(8'h11, 8'hAD);
    bk_wr(8'h12, 8'hBE); bk_wr(8'h13, 8'hEF);
    bk_wr(8'h23, 8'h77); bk_wr(8'hFE, 8'h3C);
    bk_wr(8'h30, 8'h66);
    bk_chk("bk_pre_10", 8'h10, 8'hDE);

    // Sequential read of the preloaded bytes
    bk_addr = 8'h13;
    ce_lo();
    spi_byte(8'h03, 8'h00); spi_byte(8'h00, 8'h00); spi_byte(8'h10, 8'h00);
    spi_byte(8'h00, 8'hDE); spi_byte(8'h00, 8'hAD);
    spi_byte(8'h00, 8'hBE); spi_byte(8'h00, 8'hEF);
    ce_hi();
    check8("bk_during_read", bk_rdata, 8'hEF);

    // Write burst
    ce_lo();
    spi_byte(8'h02, 8'h00); spi_byte(8'h00, 8'h00); spi_byte(8'h20, 8'h00);
    spi_byte(8'h11, 8'h00); spi_byte(8'h22, 8'h00); spi_byte(8'h33, 8'h00);
    ce_hi();
    bk_chk("wr_20", 8'h20, 8'h11);
    bk_chk("wr_21", 8'h21, 8'h22);
    bk_chk("wr_22", 8'h22, 8'h33);
    bk_chk("wr_23_untouched", 8'h23, 8'h77);

    // Write wrapping 0xFFFF -> 0x0000
    ce_lo();
    spi_byte(8'h02, 8'h00); spi_byte(8'hFF, 8'h00); spi_byte(8'hFF, 8'h00);
    spi_byte(8'hA5, 8'h00); spi_byte(8'h5A, 8'h00);
    ce_hi();
    bk_chk("wrap_wr_ff", 8'hFF, 8'hA5);
    bk_chk("wrap_wr_00", 8'h00, 8'h5A);

    // Read aliasing 0x01FE -> 0xFE, then wrapping past 0xFF
    ce_lo();
    spi_byte(8'h03, 8'h00); spi_byte(8'h01, 8'h00); spi_byte(8'hFE, 8'h00);
    spi_byte(8'h00, 8'h3C); spi_byte(8'h00, 8'hA5); spi_byte(8'h00, 8'h5A);
    ce_hi();

    // Aborted write: partial byte must not land
    ce_lo();
    spi_byte(8'h02, 8'h00); spi_byte(8'h00, 8'h00); spi_byte(8'h30, 8'h00);
    spi_bits(8'hF0, 4);
    ce_hi();
    bk_chk("abort_30", 8'h30, 8'h66);

    // Status read
    ce_lo();
    spi_byte(8'h05, 8'h00); spi_byte(8'h00, 8'h40); spi_byte(8'h00, 8'h40);
    ce_hi();

    // Unknown opcode keeps MISO low
    ce_lo();
    spi_byte(8'h9F, 8'h00); spi_byte(8'hFF, 8'h00); spi_byte(8'h00, 8'h00);
    ce_hi();

    // Reset in the middle of a read data byte
    ce_lo();
    spi_byte(8'h03, 8'h00); spi_byte(8'h00, 8'h00); spi_byte(8'h10, 8'h00);
    spi_bits(8'h00, 3);
    @(negedge clk) rst_n = 1'b0;
    wclk(2);
    check8("midrst_miso", {7'd0, spi_miso}, 8'h00);
    check8("midrst_active", {7'd0, active}, 8'h00);
    check8("midrst_bk_rdata", bk_rdata, 8'h00);
    spi_ce_n = 1'b1;
    wclk(4);
    rst_n = 1'b1;
    wclk(6);
    check8("postrst_active", {7'd0, active}, 8'h00);
    ce_lo();
    spi_byte(8'h03, 8'h00); spi_byte(8'h00, 8'h00); spi_byte(8'h10, 8'h00);
    spi_byte(8'h00, 8'hDE); spi_byte(8'h00, 8'hAD);
    ce_hi();
    bk_chk("postrst_mem_13", 8'h13, 8'hEF);
    bk_chk("postrst_mem_ff", 8'hFF, 8'hA5);

    // Every pushed expectation must have been consumed
    wclk(8);
    check8("exp_q_drained", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_sram_target.md
Name: spi_sram_target

Overview:
- Synthesizable SPI mode-0 target that models a 23LC512-style serial SRAM.
- Sits on the far end of the SPI bus driven by spi_core / mem_ctrl, in place of the external SPI RAM.
- Used for SoC-level simulation and for FPGA bring-up without a RAM chip.
- Oversamples SCK/MOSI/CE on clk; backs a local byte array; also exposes a backdoor port for preload and inspection.

Parameters:
- MEM_DEPTH, 256, bytes of backing storage; power of two, ≤ 65536.
- MEM_AW, 8, log2(MEM_DEPTH); SPI addresses index the array modulo MEM_DEPTH.
- STATUS_VAL, 8'h40, byte returned by RDSR (sequential mode).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- spi_clk  in  1  SCK from initiator (asynchronous to clk)
- spi_mosi  in  1  serial data from initiator
- spi_ce_n  in  1  chip enable, active-low
- spi_miso  out  1  serial data to initiator
- active  out  1  high while a transaction is selected and being decoded
- bk_write  in  1  backdoor write strobe
- bk_addr  in  MEM_AW  backdoor address
- bk_wdata  in  8  backdoor write data
- bk_rdata  out  8  mem[bk_addr], registered, 1-cycle latency

Behaviour:
- Clock and reset: clk, rst_n is synchronous, active-low.
- Reset values: spi_miso=0, active=0, bk_rdata=0, FSM=IDLE, bit counter=0, address=0. The memory array is not cleared.
- Input sync: spi_clk, spi_mosi, spi_ce_n each pass through a 2-flop synchronizer. SCK rise/fall are detected from the synchronized value and its previous value.
- SCK timing: high and low phases must each be ≥4 clk. Pin-to-action latency is 3 clk.
- Mode 0: MOSI is sampled on SCK rise. MISO is updated on SCK fall. Bytes are MSB first.
- CE high (synchronized): FSM goes to IDLE, bit counter clears, spi_miso=0, active=0. This applies at any point, mid-byte included.
- Partial bytes at CE rise are discarded; no memory write occurs.
- IDLE: on CE low go to CMD and set active=1.
- CMD, after 8 bits:
  - 0x03 -> ADDR_HI, read mode.
  - 0x02 -> ADDR_HI, write mode.
  - 0x05 -> RDSR.
  - Any other value -> IGNORE.
- ADDR_HI then ADDR_LO: 16-bit address, MSB first.
  - After ADDR_LO in read mode: load mem[addr mod MEM_DEPTH] into the TX shift register, go to READ.
  - After ADDR_LO in write mode: go to WRITE.
- READ:
  - MSB is driven on the first SCK fall after the last address bit.
  - Each subsequent fall shifts out the next bit.
  - After 8 bits shifted out: addr += 1 (16-bit, wraps 0xFFFF->0x0000) and the next byte is reloaded in time for the following fall.
- WRITE:
  - On the 8th sampled bit, write the byte to mem[addr mod MEM_DEPTH], then addr += 1 with the same wrap.
- RDSR: shift out STATUS_VAL repeatedly until CE rises.
- IGNORE: spi_miso=0; consume clocks until CE rises.
- MISO outside READ/RDSR data phases: 0.
- Bit counter: 3-bit, wraps every byte. Byte boundary is counter==7 on an SCK rise.
- Backdoor:
  - bk_write writes mem[bk_addr] on the clk edge.
  - bk_rdata is updated every clk from mem[bk_addr].
  - If an SPI write and bk_write hit the same address in the same cycle, the SPI write wins.
- SCK edges while CE is high are ignored.
- An SCK rise within the same synchronized cycle as CE fall is treated as the first command bit. The initiator should avoid this; the design must not hang.

Test Plan:
- Backdoor preload mem[0x10..0x13]=DE,AD,BE,EF; SPI 03 00 10 + 4 dummy bytes -> MISO bytes DE AD BE EF; bk_rdata unaffected.
- SPI 02 00 20 11 22 33, CE high; backdoor read 0x20..0x22 -> 11,22,33; 0x23 unchanged.
- Wrap, write phase (MEM_DEPTH=256): SPI 02 FF FF A5 5A -> mem[0xFF]=A5, mem[0x00]=5A.
- Wrap, read phase: SPI 03 01 FE, read 3 bytes -> mem[0xFE], mem[0xFF], mem[0x00] (0x01FE aliases to 0xFE).
- Abort, RDSR and unknown opcode:
  - SPI 02 00 30 then 4 bits of 0xF and CE high -> mem[0x30] unchanged.
  - Next 05 + 2 dummy bytes -> 40 40.
  - Opcode 0x9F + 2 dummy bytes -> MISO stays 0.
- Reset mid-READ (after 3 data bits): all outputs return to reset values; next 03 00 10 transaction reads DE correctly; memory contents preserved.
